// File: rtl/cpu2core_cpu_1_cpu_oci_dct_packer.sv
// Packs 2-bit trace frames into 15-slot words for the OCI trace path, with
// an idle timeout and an end-of-test drain sequence.
module cpu2core_cpu_1_cpu_oci_dct_packer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tr_valid,
  input  logic [1:0]  tr_frame,
  output logic        tr_ready,
  input  logic        flush,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        dct_valid,
  input  logic        dct_ready,
  output logic        test_ending,
  output logic        test_has_ended
);

  localparam int unsigned FRAME_W = 2;
  localparam int unsigned SLOTS   = 15;
  localparam int unsigned BUF_W   = FRAME_W * SLOTS;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned IDLE_W  = 16;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_ENDED
  } state_t;

  state_t             state;
  logic [BUF_W-1:0]   acc;
  logic [CNT_W-1:0]   acc_cnt;
  logic [IDLE_W-1:0]  idle;

  logic               slot_free;
  logic               accept;
  logic               acc_full;
  logic               timeout_hit;
  logic               xfer_req;
  logic               transfer;
  logic [BUF_W-1:0]   frame_ins;

  assign slot_free   = !dct_valid || dct_ready;
  assign acc_full    = (acc_cnt == CNT_W'(SLOTS));
  assign tr_ready    = (state == ST_RUN) && (!acc_full || slot_free);
  assign accept      = tr_valid && tr_ready;
  assign timeout_hit = (acc_cnt != '0) && (idle == IDLE_W'(TIMEOUT_CYCLES));
  assign xfer_req    = acc_full || timeout_hit ||
                       ((state == ST_DRAIN) && (acc_cnt != '0));
  assign transfer    = xfer_req && slot_free;

  // Incoming frame positioned at the next free accumulator slot.
  always_comb begin
    frame_ins = '0;
    for (int k = 0; k < int'(SLOTS); k++) begin
      if (CNT_W'(k) == acc_cnt) frame_ins[FRAME_W*k +: FRAME_W] = tr_frame;
    end
  end

  // Accumulator, idle counter and output word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      acc_cnt    <= '0;
      idle       <= '0;
      dct_buffer <= '0;
      dct_count  <= '0;
      dct_valid  <= 1'b0;
    end else begin
      if (transfer) begin
        dct_buffer <= acc;
        dct_count  <= acc_cnt;
        dct_valid  <= 1'b1;
        // A frame arriving alongside the transfer starts the next word.
        acc        <= accept ? BUF_W'(tr_frame) : '0;
        acc_cnt    <= accept ? CNT_W'(1) : '0;
      end else begin
        if (dct_ready) dct_valid <= 1'b0;
        if (accept) begin
          acc     <= acc | frame_ins;
          acc_cnt <= acc_cnt + CNT_W'(1);
        end
      end

      if (accept || transfer) begin
        idle <= '0;
      end else if ((acc_cnt != '0) && (idle != IDLE_W'(TIMEOUT_CYCLES))) begin
        idle <= idle + IDLE_W'(1);
      end
    end
  end

  // End-of-test sequencing: RUN -> DRAIN on flush, DRAIN -> ENDED once empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      test_ending    <= 1'b0;
      test_has_ended <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush) begin
            state       <= ST_DRAIN;
            test_ending <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if ((acc_cnt == '0) && slot_free && !transfer) begin
            state          <= ST_ENDED;
            test_has_ended <= 1'b1;
          end
        end
        ST_ENDED: begin
          state <= ST_ENDED;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu2core_cpu_1_cpu_oci_dct_packer.sv
// Directed and random bench for the trace frame packer against a queue-based model.
module tb_cpu2core_cpu_1_cpu_oci_dct_packer;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        tr_valid;
  logic [1:0]  tr_frame;
  logic        tr_ready;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid;
  logic        dct_ready;
  logic        test_ending;
  logic        test_has_ended;

  int tests = 0;
  int fails = 0;

  // Model: pending frames, delivered word, idle counter, phase (0 run, 1 drain, 2 ended)
  int m_acc[$];
  int m_out[$];
  bit m_valid;
  int m_idle;
  int m_phase;

  cpu2core_cpu_1_cpu_oci_dct_packer #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .tr_valid(tr_valid), .tr_frame(tr_frame),
    .tr_ready(tr_ready), .flush(flush), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .dct_valid(dct_valid), .dct_ready(dct_ready),
    .test_ending(test_ending), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w = 0;
    foreach (m_out[k]) w = w + (32'(m_out[k]) << (2 * k));
    return w;
  endfunction

  function automatic bit model_ready(input bit r);
    return (m_phase == 0) && (m_acc.size() != 15 || !m_valid || r);
  endfunction

  task automatic model_reset();
    m_acc.delete(); m_out.delete();
    m_valid = 0; m_idle = 0; m_phase = 0;
  endtask

  task automatic model_step(input bit v, input int f, input bit fl, input bit r);
    int  n    = m_acc.size();
    bit  free = !m_valid || r;
    bit  acc  = v && model_ready(r);
    bit  xfer = free && (n == 15 || (n > 0 && m_idle == T) || (m_phase == 1 && n > 0));
    bit  done = (m_phase == 1) && (n == 0) && free && !xfer;
    if (xfer) begin
      m_out = m_acc;
      m_acc.delete();
      m_valid = 1;
    end else if (r) begin
      m_valid = 0;
    end
    if (acc) m_acc.push_back(f);
    if (acc || xfer) m_idle = 0;
    else if (n > 0 && m_idle < T) m_idle++;
    if (m_phase == 0 && fl) m_phase = 1;
    else if (done) m_phase = 2;
  endtask

  task automatic check_outs();
    chk("dct_valid", dct_valid, m_valid);
    chk("test_ending", test_ending, m_phase != 0);
    chk("test_has_ended", test_has_ended, m_phase == 2);
    if (m_valid) begin
      chk("dct_buffer", dct_buffer, model_word());
      chk("dct_count", dct_count, m_out.size());
    end
  endtask

  // One clock: drive inputs, check tr_ready, advance model, check registered outputs.
  task automatic cyc(input bit v, input logic [1:0] f, input bit fl, input bit r);
    tr_valid = v; tr_frame = f; flush = fl; dct_ready = r;
    #1;
    chk("tr_ready", tr_ready, model_ready(r));
    model_step(v, int'(f), fl, r);
    @(posedge clk);
    #1;
    check_outs();
  endtask

  task automatic do_reset();
    reset = 1'b1; tr_valid = 1'b0; flush = 1'b0; dct_ready = 1'b0;
    #2;
    chk("rst_dct_valid", dct_valid, 0);
    chk("rst_dct_buffer", dct_buffer, 0);
    chk("rst_dct_count", dct_count, 0);
    chk("rst_test_ending", test_ending, 0);
    chk("rst_test_has_ended", test_has_ended, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic drain();
    repeat (12) cyc(1'b0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    int n;
    reset = 1'b1; tr_valid = 1'b0; tr_frame = 2'b00; flush = 1'b0; dct_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    #1;
    chk("ready_after_reset", tr_ready, 1);

    // 15 frames of 01 with the consumer always ready
    repeat (15) cyc(1'b1, 2'b01, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("full_valid", dct_valid, 1);
    chk("full_buffer", dct_buffer, 32'h15555555);
    chk("full_count", dct_count, 15);
    drain();

    // Backpressure: 30 frames with consumer stalled
    repeat (30) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("bp_ready_low", tr_ready, 0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("bp_second_valid", dct_valid, 1);
    chk("bp_second_count", dct_count, 15);
    #1;
    chk("bp_ready_back", tr_ready, 1);
    drain();

    // Idle timeout on a partial word
    repeat (3) cyc(1'b1, 2'b11, 1'b0, 1'b1);
    n = 0;
    while (!dct_valid && n < 10) begin
      cyc(1'b0, 2'b00, 1'b0, 1'b1);
      n++;
    end
    chk("timeout_latency", n, 5);
    chk("timeout_buffer", dct_buffer, 32'h3F);
    chk("timeout_count", dct_count, 3);
    drain();

    // 15th frame coincides with the consumer taking the previous word
    repeat (29) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 2'b10, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("coincident_count", dct_count, 15);
    drain();

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, 2'($urandom), 1'b0, ($urandom % 3) != 0);
    drain();

    // Reset with a partial accumulator and a pending word
    repeat (22) cyc(1'b1, 2'($urandom), 1'b0, 1'b0);
    chk("pre_reset_valid", dct_valid, 1);
    do_reset();
    repeat (15) cyc(1'b1, 2'($urandom), 1'b0, 1'b1);
    chk("post_reset_no_word", dct_valid, 0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("post_reset_word", dct_count, 15);
    drain();

    // Flush with two frames buffered
    cyc(1'b1, 2'b10, 1'b0, 1'b1);
    cyc(1'b1, 2'b01, 1'b0, 1'b1);
    cyc(1'b0, 2'b00, 1'b1, 1'b1);
    chk("flush_ending", test_ending, 1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("flush_buffer", dct_buffer, 32'h6);
    chk("flush_count", dct_count, 2);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("flush_ended", test_has_ended, 1);
    cyc(1'b1, 2'b11, 1'b1, 1'b1);
    chk("ended_ready_low", tr_ready, 0);
    chk("ended_sticky", test_has_ended, 1);

    // Flush when completely empty
    do_reset();
    cyc(1'b0, 2'b00, 1'b1, 1'b1);
    chk("empty_flush_not_yet", test_has_ended, 0);
    cyc(1'b0, 2'b00, 1'b0, 1'b1);
    chk("empty_flush_ended", test_has_ended, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
